branch_unit: RTL and testbench

//  Parametrised branch resolution and prediction unit for the RV32I core.
//  - Resolves BRANCH/JAL/JALR in EX: condition, target, mispredict/redirect.
//  - Keeps a PC-indexed table (BHT) of saturating counters, read by fetch.
//  - Sits between the fetch PC mux (prediction) and the EX stage (resolution/flush).

---
 rtl/branch_unit.sv | 116 +++++++++++
 tb/tb_branch_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// branch_unit: RV32I branch resolution + BHT prediction; `define BRANCH_PERF_EN adds branch/mispredict perf counters
module branch_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_BITS    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            f_valid,
   input  logic [XLEN-1:0] f_pc,
   output logic            f_pred_valid,
   output logic            f_pred_taken,
   input  logic            ex_valid,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   output logic            br_valid,
   output logic            br_taken,
   output logic [XLEN-1:0] br_target,
   output logic            br_mispredict,
`ifdef BRANCH_PERF_EN
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts,
`endif
   output logic            init_done
);
   localparam int IDX = $clog2(BHT_ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   typedef enum logic {INIT, RUN} state_t;
   state_t state, state_n;
   logic [IDX-1:0] init_ptr, init_ptr_n;
   logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
   logic is_br, is_jal, is_jalr, ctl, br_ok, cond, taken, mis, upd;
   logic [XLEN-1:0] target;
   logic [IDX-1:0] f_idx, ex_idx;
   logic [CTR_BITS-1:0] ctr_cur, ctr_new, f_ctr;
   logic unused_f_pc;
   assign unused_f_pc = ^{f_pc[XLEN-1:IDX+2], f_pc[1:0]};
   assign init_done = state == RUN;
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= INIT;
         init_ptr <= '0;
      end else begin
         state    <= state_n;
         init_ptr <= init_ptr_n;
      end
   end
   always_comb begin
      state_n    = (state == INIT && init_ptr == IDX'(BHT_ENTRIES - 1)) ? RUN : state;
      init_ptr_n = (state == INIT) ? init_ptr + IDX'(1) : init_ptr;
   end
   assign is_br   = ex_opcode == 7'b1100011;
   assign is_jal  = ex_opcode == 7'b1101111;
   assign is_jalr = ex_opcode == 7'b1100111;
   assign ctl     = ex_valid && (is_br || is_jal || is_jalr);
   assign br_ok   = ex_funct3[2:1] != 2'b01;
   always_comb begin
      cond = (ex_funct3[2:1] == 2'b00) ? (ex_rs1 == ex_rs2) ^ ex_funct3[0] :
             (ex_funct3[2:1] == 2'b10) ? ($signed(ex_rs1) < $signed(ex_rs2)) ^ ex_funct3[0] :
             (ex_funct3[2:1] == 2'b11) ? (ex_rs1 < ex_rs2) ^ ex_funct3[0] : 1'b0;
      taken  = is_br ? cond : 1'b1;
      target = is_jalr ? (ex_rs1 + ex_imm) & ~XLEN'(1) :
               taken   ? ex_pc + ex_imm : ex_pc + XLEN'(4);
      mis    = is_br ? taken ^ ex_pred_taken : 1'b1;
   end
   // Counter update path; fetch sees the post-update value when it hits the same entry
   assign f_idx   = f_pc[IDX+1:2];
   assign ex_idx  = ex_pc[IDX+1:2];
   assign upd     = ex_valid && is_br && br_ok && state == RUN;
   assign ctr_cur = bht[ex_idx];
   assign ctr_new = cond ? ((&ctr_cur) ? ctr_cur : ctr_cur + CTR_BITS'(1)) :
                           ((|ctr_cur) ? ctr_cur - CTR_BITS'(1) : ctr_cur);
   assign f_ctr   = (upd && ex_idx == f_idx) ? ctr_new : bht[f_idx];
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT)
            bht[init_ptr] <= CTR_INIT;
         else if (upd)
            bht[ex_idx] <= ctr_new;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         f_pred_valid  <= 1'b0;
         f_pred_taken  <= 1'b0;
         br_valid      <= 1'b0;
         br_taken      <= 1'b0;
         br_target     <= '0;
         br_mispredict <= 1'b0;
      end else begin
         f_pred_valid  <= f_valid;
         f_pred_taken  <= f_valid && state == RUN && f_ctr[CTR_BITS-1];
         br_valid      <= ctl;
         br_taken      <= ctl && taken;
         br_target     <= ctl ? target : '0;
         br_mispredict <= ctl && mis;
      end
   end
`ifdef BRANCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else if (ex_valid && is_br) begin
         perf_branches <= perf_branches + {31'd0, ~&perf_branches};
         if (mis)
            perf_mispredicts <= perf_mispredicts + {31'd0, ~&perf_mispredicts};
      end
   end
`endif
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed vector table plus init/training/reset sequences for branch_unit
module tb_branch_unit;
   localparam logic [6:0] BR = 7'h63, JAL = 7'h6F, JALR = 7'h67, OPI = 7'h13;
   logic clk = 1'b0, reset = 1'b1;
   logic f_valid = 1'b0, f_pred_valid, f_pred_taken;
   logic [31:0] f_pc = '0;
   logic ex_valid = 1'b0, ex_pred_taken = 1'b0;
   logic [6:0] ex_opcode = '0;
   logic [2:0] ex_funct3 = '0;
   logic [31:0] ex_pc = '0, ex_rs1 = '0, ex_rs2 = '0, ex_imm = '0;
   logic br_valid, br_taken, br_mispredict, init_done;
   logic [31:0] br_target;
`ifdef BRANCH_PERF_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif
   int checks = 0, errors = 0;
   branch_unit dut (
      .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
      .f_pred_valid(f_pred_valid), .f_pred_taken(f_pred_taken),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
      .ex_pred_taken(ex_pred_taken), .br_valid(br_valid), .br_taken(br_taken),
      .br_target(br_target), .br_mispredict(br_mispredict),
`ifdef BRANCH_PERF_EN
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
`endif
      .init_done(init_done)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic v; logic [6:0] op; logic [2:0] f3;
      logic [31:0] pc, rs1, rs2, imm; logic pred;
      logic ev, et; logic [31:0] etg; logic em;
   } vec_t;
   vec_t vecs[13];
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic pred);
      ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_pc = pc;
      ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm; ex_pred_taken = pred;
   endtask
   task automatic chk_br(input string name, input logic v, input logic t, input logic [31:0] tg, input logic m);
      chk({name, ".valid"}, {31'd0, br_valid}, {31'd0, v});
      chk({name, ".taken"}, {31'd0, br_taken}, {31'd0, t});
      chk({name, ".target"}, br_target, tg);
      chk({name, ".mispred"}, {31'd0, br_mispredict}, {31'd0, m});
   endtask
   task automatic predict(input string name, input logic [31:0] pc, input logic exp);
      ex_valid = 1'b0; f_valid = 1'b1; f_pc = pc;
      tick;
      chk({name, ".pvalid"}, {31'd0, f_pred_valid}, 32'd1);
      chk({name, ".ptaken"}, {31'd0, f_pred_taken}, {31'd0, exp});
   endtask
   // Walk the 64-cycle initialisation; optionally resolve a BEQ mid-way to show INIT leaves the BHT alone
   task automatic do_init(input bit with_br);
      f_valid = 1'b1; f_pc = 32'h100;
      for (int i = 0; i < 64; i++) begin
         if (with_br && i == 10) set_ex(1'b1, BR, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
         else ex_valid = 1'b0;
         tick;
         chk($sformatf("init%0d.done", i), {31'd0, init_done}, {31'd0, i == 63});
         chk($sformatf("init%0d.ptaken", i), {31'd0, f_pred_taken}, 32'd0);
         if (i == 0) chk("init.pvalid", {31'd0, f_pred_valid}, 32'd1);
         if (with_br && i == 10) begin
            chk_br("init_beq", 1'b1, 1'b1, 32'h120, 1'b1);
`ifdef BRANCH_PERF_EN
            chk("perf.branches", perf_branches, 32'd1);
            chk("perf.mispredicts", perf_mispredicts, 32'd1);
`endif
         end
      end
      ex_valid = 1'b0;
   endtask
   initial begin
      vecs[0]  = '{1'b1, BR,   3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b1, 1'b1, 32'h120, 1'b1};
      vecs[1]  = '{1'b1, BR,   3'd1, 32'h204, 32'd5, 32'd5, 32'h40, 1'b1, 1'b1, 1'b0, 32'h208, 1'b1};
      vecs[2]  = '{1'b1, BR,   3'd4, 32'h208, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h218, 1'b0};
      vecs[3]  = '{1'b1, BR,   3'd6, 32'h20C, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h210, 1'b0};
      vecs[4]  = '{1'b1, BR,   3'd5, 32'h210, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1};
      vecs[5]  = '{1'b1, BR,   3'd7, 32'h214, 32'd1, 32'hFFFFFFFF, 32'h8, 1'b1, 1'b1, 1'b0, 32'h218, 1'b1};
      vecs[6]  = '{1'b1, JAL,  3'd0, 32'h300, 32'd0, 32'd0, 32'h100, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1};
      vecs[7]  = '{1'b1, JALR, 3'd0, 32'h43C, 32'h1003, 32'd0, 32'h4, 1'b1, 1'b1, 1'b1, 32'h1006, 1'b1};
      vecs[8]  = '{1'b1, BR,   3'd2, 32'h218, 32'd5, 32'd5, 32'h20, 1'b0, 1'b1, 1'b0, 32'h21C, 1'b0};
      vecs[9]  = '{1'b1, OPI,  3'd0, 32'h500, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[10] = '{1'b1, JAL,  3'd0, 32'hFFFFFFF0, 32'd0, 32'd0, 32'h20, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1};
      vecs[11] = '{1'b0, BR,   3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[12] = '{1'b1, BR,   3'd3, 32'h218, 32'd1, 32'd2, 32'h20, 1'b1, 1'b1, 1'b0, 32'h21C, 1'b1};
      tick;
      chk("rst.init_done", {31'd0, init_done}, 32'd0);
      chk("rst.br_valid", {31'd0, br_valid}, 32'd0);
      chk("rst.pvalid", {31'd0, f_pred_valid}, 32'd0);
      reset = 1'b0;
      do_init(1'b0);
      f_valid = 1'b0;
      foreach (vecs[k]) begin
         set_ex(vecs[k].v, vecs[k].op, vecs[k].f3, vecs[k].pc, vecs[k].rs1, vecs[k].rs2, vecs[k].imm, vecs[k].pred);
         tick;
         chk_br($sformatf("vec%0d", k), vecs[k].ev, vecs[k].et, vecs[k].etg, vecs[k].em);
      end
      predict("p_beq", 32'h100, 1'b1);
      predict("p_bne", 32'h204, 1'b0);
      predict("p_blt", 32'h208, 1'b1);
      predict("p_bltu", 32'h20C, 1'b0);
      predict("p_bge", 32'h210, 1'b1);
      predict("p_jalr", 32'h43C, 1'b0);
      predict("p_f010", 32'h218, 1'b0);
      f_valid = 1'b0; f_pc = 32'h100;
      tick;
      chk("nofetch.pvalid", {31'd0, f_pred_valid}, 32'd0);
      chk("nofetch.ptaken", {31'd0, f_pred_taken}, 32'd0);
      f_valid = 1'b1; f_pc = 32'h84;
      set_ex(1'b1, BR, 3'd0, 32'h84, 32'd7, 32'd7, 32'h8, 1'b0);
      tick;
      chk("bypass.ptaken", {31'd0, f_pred_taken}, 32'd1);
      chk("bypass.taken", {31'd0, br_taken}, 32'd1);
      f_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_ex(1'b1, BR, 3'd0, 32'h80, 32'd1, 32'd1, 32'h8, 1'b1);
         tick;
      end
      f_valid = 1'b1; f_pc = 32'h80;
      set_ex(1'b1, BR, 3'd1, 32'h80, 32'd1, 32'd1, 32'h8, 1'b1);
      tick;
      chk("sat_nt1.ptaken", {31'd0, f_pred_taken}, 32'd1);
      chk("sat_nt1.mispred", {31'd0, br_mispredict}, 32'd1);
      tick;
      chk("sat_nt2.ptaken", {31'd0, f_pred_taken}, 32'd0);
      reset = 1'b1;
      set_ex(1'b1, JAL, 3'd0, 32'h300, 32'd0, 32'd0, 32'h100, 1'b0);
      f_pc = 32'h100;
      tick;
      chk("rst2.pvalid", {31'd0, f_pred_valid}, 32'd0);
      chk("rst2.ptaken", {31'd0, f_pred_taken}, 32'd0);
      chk_br("rst2", 1'b0, 1'b0, 32'h0, 1'b0);
      chk("rst2.init_done", {31'd0, init_done}, 32'd0);
`ifdef BRANCH_PERF_EN
      chk("rst2.perf_br", perf_branches, 32'd0);
      chk("rst2.perf_mis", perf_mispredicts, 32'd0);
`endif
      reset = 1'b0;
      do_init(1'b1);
      predict("retrained", 32'h100, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
